// File: rtl/slot_sense_debounce.sv
// Six-slot parking sensor conditioner: 2-flop synchronizers, per-slot debounce, occupancy summary.
// Optional macro SLOT_DEBOUNCE_EN enables the per-slot stability counters; otherwise slots follow the synchronizer directly.
module slot_sense_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [5:0] sensor_raw,
  output logic [5:0] slot_occ,
  output logic [2:0] free_cnt,
  output logic       full,
  output logic       empty,
  output logic       occ_change
);

  logic [5:0] sync1;
  logic [5:0] sync2;
  logic [5:0] occ_next;
  logic [2:0] ones;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= sensor_raw;
      sync2 <= sync1;
    end
  end

  // Legal DEBOUNCE_CYCLES is 1..255; this empty branch only marks an out-of-range build.
  if (DEBOUNCE_CYCLES < 1 || DEBOUNCE_CYCLES > 255) begin : g_debounce_cycles_out_of_range
  end

`ifdef SLOT_DEBOUNCE_EN
  localparam logic [7:0] LAST = 8'(DEBOUNCE_CYCLES - 1);

  for (genvar gi = 0; gi < 6; gi++) begin : g_slot
    logic [7:0] cnt;
    logic       differs;

    assign differs = (sync2[gi] != slot_occ[gi]);

    // The counter holds how many earlier consecutive cycles already disagreed.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        cnt <= '0;
      end else if (!differs || cnt == LAST) begin
        cnt <= '0;
      end else begin
        cnt <= cnt + 8'd1;
      end
    end

    assign occ_next[gi] = (differs && cnt == LAST) ? sync2[gi] : slot_occ[gi];
  end
`else
  assign occ_next = sync2;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot_occ   <= '0;
      occ_change <= 1'b0;
    end else begin
      slot_occ   <= occ_next;
      occ_change <= (occ_next != slot_occ);
    end
  end

  always_comb begin
    ones = '0;
    for (int i = 0; i < 6; i++) begin
      ones = ones + {2'b00, slot_occ[i]};
    end
  end

  assign free_cnt = 3'd6 - ones;
  assign full     = (slot_occ == 6'b111111);
  assign empty    = (slot_occ == 6'b000000);

endmodule

// File: tb/tb_slot_sense_debounce.sv
// Bench for slot_sense_debounce: directed scenarios plus random sensor activity against a window-based reference model.
module tb_slot_sense_debounce;

  localparam int D = 4;
`ifdef SLOT_DEBOUNCE_EN
  localparam int DE = D;
`else
  localparam int DE = 1;
`endif
  localparam int LAT = 2 + DE;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic [5:0] sensor_raw = '0;
  logic [5:0] slot_occ;
  logic [2:0] free_cnt;
  logic       full;
  logic       empty;
  logic       occ_change;

  int checks = 0;
  int fails  = 0;

  // Reference: history of sampled sensor words (index 0 = newest edge) and accepted occupancy.
  logic [5:0] hist[$];
  logic [5:0] occ_m;
  logic       chg_m;

  slot_sense_debounce #(.DEBOUNCE_CYCLES(D)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .sensor_raw (sensor_raw),
    .slot_occ   (slot_occ),
    .free_cnt   (free_cnt),
    .full       (full),
    .empty      (empty),
    .occ_change (occ_change)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    hist.delete();
    for (int i = 0; i < DE + 2; i++) hist.push_front(6'b0);
    occ_m = '0;
    chg_m = 1'b0;
  endtask

  // A slot flips when the synchronized value (two edges old) has disagreed with it for DE edges in a row.
  task automatic model_edge(input logic [5:0] val);
    logic [5:0] prev;
    logic       all;
    hist.push_front(val);
    while (hist.size() > DE + 2) void'(hist.pop_back());
    prev = occ_m;
    for (int b = 0; b < 6; b++) begin
      all = 1'b1;
      for (int j = 2; j <= DE + 1; j++) if (hist[j][b] == prev[b]) all = 1'b0;
      if (all) occ_m[b] = ~prev[b];
    end
    chg_m = (occ_m != prev);
  endtask

  task automatic check_outputs(input string tag);
    chk({tag, ".slot_occ"}, {2'b0, slot_occ}, {2'b0, occ_m});
    chk({tag, ".free_cnt"}, {5'b0, free_cnt}, 8'(6 - $countones(occ_m)));
    chk({tag, ".full"}, {7'b0, full}, {7'b0, occ_m == 6'b111111});
    chk({tag, ".empty"}, {7'b0, empty}, {7'b0, occ_m == 6'b000000});
    chk({tag, ".occ_change"}, {7'b0, occ_change}, {7'b0, chg_m});
  endtask

  task automatic step(input logic [5:0] val);
    sensor_raw = val;
    @(posedge clk);
    model_edge(val);
    #1;
    check_outputs("step");
    $display("edge sensor=%06b slot_occ=%06b free=%0d full=%0b empty=%0b chg=%0b",
             val, slot_occ, free_cnt, full, empty, occ_change);
  endtask

  // Holds val and counts edges up to and including the first occ_change pulse.
  task automatic measure(input string tag, input logic [5:0] val, input int exp);
    int n = 0;
    do begin
      step(val);
      n++;
    end while (occ_change !== 1'b1 && n < 20);
    chk(tag, 8'(n), 8'(exp));
  endtask

  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    chk("rst.slot_occ", {2'b0, slot_occ}, 8'h00);
    chk("rst.free_cnt", {5'b0, free_cnt}, 8'd6);
    chk("rst.full", {7'b0, full}, 8'd0);
    chk("rst.empty", {7'b0, empty}, 8'd1);
    chk("rst.occ_change", {7'b0, occ_change}, 8'd0);
    $display("reset asserted: slot_occ=%06b free=%0d", slot_occ, free_cnt);
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
    model_reset();
  endtask

  initial begin
    logic [5:0] cur;
    int hold;
    model_reset();
    #3;
    apply_reset();

    // Single car in slot A
    measure("lat_slot_a", 6'b100000, LAT);
    chk("slot_a.free_cnt", {5'b0, free_cnt}, 8'd5);
    repeat (3) step(6'b100000);

    // Short excursion on slot C, then everything clear
    for (int i = 0; i < LAT + 2; i++) step(6'b000000);
    repeat (3) step(6'b001000);
    for (int i = 0; i < LAT + 4; i++) step(6'b000000);

    // All slots fill at once
    measure("lat_all", 6'b111111, LAT);
    chk("all.full", {7'b0, full}, 8'd1);
    chk("all.free_cnt", {5'b0, free_cnt}, 8'd0);
    repeat (3) step(6'b111111);

    // Reset in the middle of a debounce, sensors held
    for (int i = 0; i < LAT + 2; i++) step(6'b110010);
    repeat (3) step(6'b110110);
    sensor_raw = 6'b110010;
    apply_reset();
    measure("lat_after_rst", 6'b110010, LAT);
    repeat (2) step(6'b110010);

    // One-cycle glitch on slot F
    for (int i = 0; i < LAT + 4; i++) step(6'b000000);
    step(6'b000001);
    for (int i = 0; i < LAT + 4; i++) step(6'b000000);

    // Random sensor activity with hold times straddling the debounce window
    cur = '0;
    for (int s = 0; s < 250; s++) begin
      cur = cur ^ 6'($urandom_range(0, 63) & $urandom_range(0, 63));
      hold = $urandom_range(1, DE + 3);
      for (int h = 0; h < hold; h++) step(cur);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/slot_sense_debounce.md
SLOT_SENSE_DEBOUNCE -- requirements
Module: slot_sense_debounce

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 4, meaning consecutive stable cycles required before a slot state is accepted (legal range 1..255).
REQ-002 SHALL have port clk  input  1  single system clock, all state on rising edge.
REQ-003 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port sensor_raw  input  6  asynchronous slot sensors, 1 = car present; bit5 = slot A ... bit0 = slot F.
REQ-005 SHALL have port slot_occ  output  6  accepted occupancy, same bit order; drives the flag display stage inputs A..F directly.
REQ-006 SHALL have port free_cnt  output  3  number of free slots, 0..6.
REQ-007 SHALL have port full  output  1  high when all six slots are occupied.
REQ-008 SHALL have port empty  output  1  high when no slot is occupied.
REQ-009 SHALL have port occ_change  output  1  one-cycle pulse when slot_occ changes.

Function
REQ-010 SHALL pass each sensor_raw bit through a 2-flop synchronizer before any other use.
REQ-011 SHALL keep an independent 8-bit stability counter per slot.
REQ-012 SHALL clear a slot's counter on any cycle where its synchronized value equals its slot_occ bit.
REQ-013 SHALL increment a slot's counter on each cycle where its synchronized value differs from its slot_occ bit and the counter is below DEBOUNCE_CYCLES-1.
REQ-014 SHALL load the synchronized value into the slot_occ bit and clear the counter on the edge where the value differs and the counter equals DEBOUNCE_CYCLES-1.
REQ-015 SHALL give latency of exactly 2+DEBOUNCE_CYCLES rising edges from the first edge sampling a stable new sensor_raw level to slot_occ updating.
REQ-016 SHALL reject any sensor excursion shorter than DEBOUNCE_CYCLES synchronized cycles, leaving slot_occ unchanged with no occ_change pulse.
REQ-017 SHALL process slots independently; simultaneous acceptance in several slots SHALL update all of them on the same edge.
REQ-018 SHALL derive free_cnt = 6 - popcount(slot_occ), full = (slot_occ == 6'b111111) and empty = (slot_occ == 0) combinationally from the slot_occ register, valid in the same cycle.
REQ-019 SHALL assert occ_change for exactly one cycle, registered, in the first cycle the new slot_occ is visible; one pulse regardless of how many bits changed on that edge.
REQ-020 SHALL keep occ_change low when a slot changes back and forth within the debounce window.

Reset
REQ-021 SHALL, while rst_n is low, immediately force slot_occ=0, free_cnt=6, full=0, empty=1, occ_change=0, and clear all synchronizer flops and counters.
REQ-022 SHALL, after reset releases mid-operation, restart debouncing from zero with no carried-over counts; a car already present is accepted 2+DEBOUNCE_CYCLES edges after release and generates an occ_change pulse.

Configuration
REQ-023 SHALL use macro SLOT_DEBOUNCE_EN: when defined, REQ-011..REQ-016 apply.
REQ-024 SHALL, when SLOT_DEBOUNCE_EN is undefined, omit the counters and load slot_occ from the synchronizer output on every edge (3-edge latency, DEBOUNCE_CYCLES ignored), with REQ-018/REQ-019 unchanged.

Verification (DEBOUNCE_CYCLES=4, SLOT_DEBOUNCE_EN defined unless noted)
REQ-025 SHALL cover: reset then sensor_raw=6'b100000 held -> slot_occ=6'b100000, free_cnt=5, occ_change pulse, exactly 6 edges after first sample.
REQ-026 SHALL cover: bit3 high for 3 cycles then low -> slot_occ stays 0, occ_change never asserts.
REQ-027 SHALL cover: sensor_raw 0 -> 6'b111111 in one step -> single occ_change pulse, full=1, empty=0, free_cnt=0.
REQ-028 SHALL cover: slot_occ=6'b110010, rst_n pulsed low mid-debounce with sensors held -> outputs 0/6/0/1 immediately, slot_occ=6'b110010 again 6 edges after release.
REQ-029 SHALL cover: SLOT_DEBOUNCE_EN undefined, bit0 one-cycle glitch -> slot_occ bit0 high for one cycle, 3 edges after sampling, two occ_change pulses.
